// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner
//   Conditions raw board slide switches: per-bit metastability synchronizer,
//   per-bit debounce counter and a change detector. Feeds the clean switch
//   vector used by the core/display logic; single clk domain.
//
//   Build option: define SW_DEBOUNCE_EN for the full per-bit debounce. Without
//   it (fast simulation build) the synchronized value is registered straight
//   onto sw_stable, sw_busy is tied low and the port list is unchanged.
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high; clears all state
//   sw_raw     in   WIDTH  unsynchronized switch pins
//   sw_stable  out  WIDTH  debounced switch value, registered
//   sw_changed out  1      one-cycle pulse when sw_stable takes a new value
//   sw_valid   out  1      start-up settle window elapsed; sticky until reset
//   sw_busy    out  1      any bit's debounce counter non-zero
module sw_input_conditioner #(
  parameter int unsigned WIDTH           = 5,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic             sw_valid,
  output logic             sw_busy
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("sw_input_conditioner: SYNC_STAGES must be >=2 and DEBOUNCE_CYCLES >=1");
  end

`ifdef SW_DEBOUNCE_EN
  localparam int unsigned VALID_EDGES = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
`else
  localparam int unsigned VALID_EDGES = SYNC_STAGES + 1;
`endif
  localparam int unsigned VCNT_W = $clog2(VALID_EDGES + 1);

  // Synchronizer chain; only the last stage is used downstream.
  logic [WIDTH-1:0] sync_chain_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_chain_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;

  logic [WIDTH-1:0]  stable_q, stable_d;
  logic              changed_q, changed_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [VCNT_W-1:0] valid_cnt_q, valid_cnt_d;

  always_comb begin
    sync_chain_d    = sync_chain_q;
    sync_chain_d[0] = sw_raw;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      sync_chain_d[s] = sync_chain_q[s-1];
    end
  end

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

`ifdef SW_DEBOUNCE_EN
  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_e;

  deb_state_e       state_q [WIDTH];
  deb_state_e       state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    busy_d   = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      case (state_q[i])
        ST_STABLE: begin
          if (sync_q[i] != stable_q[i]) begin
            // A one-cycle debounce accepts on the first differing edge.
            if (DEBOUNCE_CYCLES == 1) begin
              stable_d[i] = sync_q[i];
            end else begin
              state_d[i] = ST_COUNTING;
              cnt_d[i]   = CNT_W'(1);
            end
          end
        end
        ST_COUNTING: begin
          if (sync_q[i] == stable_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d[i] = sync_q[i];
            state_d[i]  = ST_STABLE;
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
      if (cnt_d[i] != '0) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  always_comb begin
    stable_d = sync_q;
    busy_d   = 1'b0;
  end
`endif

  // Start-up window: count edges after reset release, saturate once valid.
  always_comb begin
    valid_cnt_d = valid_cnt_q;
    valid_d     = valid_q;
    if (!valid_q) begin
      valid_cnt_d = valid_cnt_q + VCNT_W'(1);
      if (valid_cnt_q == VCNT_W'(VALID_EDGES - 1)) begin
        valid_d = 1'b1;
      end
    end
  end

  // One pulse per update edge regardless of how many bits moved.
  always_comb begin
    changed_d = valid_q && (stable_d != stable_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_chain_q[s] <= '0;
      end
      stable_q    <= '0;
      changed_q   <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      valid_cnt_q <= '0;
    end else begin
      sync_chain_q <= sync_chain_d;
      stable_q     <= stable_d;
      changed_q    <= changed_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      valid_cnt_q  <= valid_cnt_d;
    end
  end

  assign sw_stable  = stable_q;
  assign sw_changed = changed_q;
  assign sw_valid   = valid_q;
  assign sw_busy    = busy_q;

endmodule
